// File: rtl/pf_lanectrl_pause_sync_mc_if.sv
// Lane-control pause bus: asynchronous per-lane pause requests in, synchronised
// pauses and ANY/ALL aggregates out.
interface pf_lanectrl_pause_sync_mc_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE;
    logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC;
    logic                 PAUSE_ANY;
    logic                 PAUSE_ALL;

    modport master (
        output HS_IO_CLK_PAUSE,
        input  HS_IO_CLK_PAUSE_SYNC,
        input  PAUSE_ANY,
        input  PAUSE_ALL
    );

    modport slave (
        input  HS_IO_CLK_PAUSE,
        output HS_IO_CLK_PAUSE_SYNC,
        output PAUSE_ANY,
        output PAUSE_ALL
    );
endinterface

// File: rtl/pf_lanectrl_pause_sync_mc.sv
// Multi-lane HS_IO clock-pause synchroniser with minimum-width stretch and post-release guard.
// Optional macro PF_LANECTRL_PAUSE_NEGEDGE_OUT_EN adds a falling-edge retiming flop per lane output.
module pf_lanectrl_pause_sync_mc #(
    parameter int NUM_LANES        = 4,
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_PAUSE_CYCLES = 4,
    parameter int GUARD_CYCLES     = 2
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    pf_lanectrl_pause_sync_mc_if.slave    bus
);

    localparam int CNT_MAX =
        (MIN_PAUSE_CYCLES > GUARD_CYCLES)
            ? ((MIN_PAUSE_CYCLES > 2) ? MIN_PAUSE_CYCLES : 2)
            : ((GUARD_CYCLES > 2) ? GUARD_CYCLES : 2);
    localparam int CW = $clog2(CNT_MAX);

    localparam logic [CW-1:0] CNT_MIN   = CW'(MIN_PAUSE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GUARD  = 2'd2
    } state_e;

    if (NUM_LANES < 1) begin : g_chk_lanes
        $error("pf_lanectrl_pause_sync_mc: NUM_LANES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_stages
        $error("pf_lanectrl_pause_sync_mc: SYNC_STAGES must be >= 2");
    end
    if (MIN_PAUSE_CYCLES < 1) begin : g_chk_min
        $error("pf_lanectrl_pause_sync_mc: MIN_PAUSE_CYCLES must be >= 1");
    end

    logic [NUM_LANES-1:0] pause_sync;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        (* syn_keep = 1, HS_IO_CLK_PAUSE_SYNC = 1 *)
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_e                 state_q;
        logic [CW-1:0]          cnt_q;
        logic                   out_q;

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.HS_IO_CLK_PAUSE[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // out_q follows the state one edge later, giving SYNC_STAGES+1 edges of latency
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                out_q   <= 1'b0;
            end else begin
                out_q <= (state_q == ST_ASSERT);
                unique case (state_q)
                    ST_IDLE: begin
                        if (s) begin
                            state_q <= ST_ASSERT;
                            cnt_q   <= CNT_MIN;
                        end
                    end
                    ST_ASSERT: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else if (!s) begin
                            if (GUARD_CYCLES > 0) begin
                                state_q <= ST_GUARD;
                                cnt_q   <= CNT_GUARD;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_GUARD: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else if (s) begin
                            state_q <= ST_ASSERT;
                            cnt_q   <= CNT_MIN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

`ifdef PF_LANECTRL_PAUSE_NEGEDGE_OUT_EN
        logic neg_q;

        always_ff @(negedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                neg_q <= 1'b0;
            end else begin
                neg_q <= out_q;
            end
        end

        assign pause_sync[i] = neg_q;
`else
        assign pause_sync[i] = out_q;
`endif
    end

    assign bus.HS_IO_CLK_PAUSE_SYNC = pause_sync;
    assign bus.PAUSE_ANY            = |pause_sync;
    assign bus.PAUSE_ALL            = &pause_sync;

endmodule

// File: tb/tb_pf_lanectrl_pause_sync_mc.sv
// Scoreboard bench: each stimulus pushes expected pause windows (channel, first cycle, width);
// a monitor closes a window on each falling output and pops the matching expectation.
module tb_pf_lanectrl_pause_sync_mc;
    localparam int NL   = 4;
    localparam int SS   = 2;
    localparam int MINC = 4;
    localparam int GC   = 2;
`ifdef PF_LANECTRL_PAUSE_NEGEDGE_OUT_EN
    localparam int LAT  = SS + 2;
`else
    localparam int LAT  = SS + 1;
`endif
    localparam int CH_ANY = NL;
    localparam int CH_ALL = NL + 1;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [NL-1:0] pause;

    pf_lanectrl_pause_sync_mc_if #(.NUM_LANES(NL)) bus ();
    assign bus.HS_IO_CLK_PAUSE = pause;

    pf_lanectrl_pause_sync_mc #(
        .NUM_LANES        (NL),
        .SYNC_STAGES      (SS),
        .MIN_PAUSE_CYCLES (MINC),
        .GUARD_CYCLES     (GC)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int rise;
        int width;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic push(input int ch, input int rise, input int width);
        ev_t e;
        e.ch = ch; e.rise = rise; e.width = width;
        exp_q.push_back(e);
    endtask

    task automatic match(input int ch, input int rise, input int width);
        int idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k].ch == ch) begin
                idx = k;
                break;
            end
        end
        if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pause ch%0d: got rise %0d width %0d, required no pause", ch, rise, width);
        end else begin
            n_tests++;
            if (exp_q[idx].rise != rise) begin
                n_fail++;
                $display("FAIL rise ch%0d: got cycle %0d, required %0d", ch, rise, exp_q[idx].rise);
            end
            n_tests++;
            if (exp_q[idx].width != width) begin
                n_fail++;
                $display("FAIL width ch%0d: got %0d cycles, required %0d", ch, width, exp_q[idx].width);
            end
            exp_q.delete(idx);
        end
    endtask

    // Monitor: channels 0..NL-1 are lane outputs, then ANY, then ALL
    logic [NL+1:0] prev = '0;
    logic [NL+1:0] cur;
    int            rs [NL+2];
    int            wd [NL+2];

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cur = {bus.PAUSE_ALL, bus.PAUSE_ANY, bus.HS_IO_CLK_PAUSE_SYNC};
            for (int c = 0; c < NL + 2; c++) begin
                if (cur[c] && !prev[c]) begin
                    rs[c] = cyc;
                    wd[c] = 1;
                end else if (cur[c]) begin
                    wd[c]++;
                end else if (prev[c]) begin
                    match(c, rs[c], wd[c]);
                end
            end
            prev = cur;
        end
    end

    task automatic check_zero(input string name);
        n_tests++;
        if (bus.HS_IO_CLK_PAUSE_SYNC !== '0 || bus.PAUSE_ANY !== 1'b0 || bus.PAUSE_ALL !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got sync=%b any=%b all=%b, required all 0", name,
                     bus.HS_IO_CLK_PAUSE_SYNC, bus.PAUSE_ANY, bus.PAUSE_ALL);
        end
    endtask

    // Called at a negedge; input sampled high on w consecutive edges
    task automatic drive(input int lane, input int w, input bit expect_it);
        int a = cyc;
        if (expect_it) begin
            push(lane, a + 1 + LAT, (w > MINC) ? w : MINC);
        end
        pause[lane] = 1'b1;
        repeat (w) @(negedge CLK);
        pause[lane] = 1'b0;
    endtask

    initial begin
        int a;
        int c;
        RESET_N = 1'b0;
        pause   = '0;
        repeat (3) @(negedge CLK);
        check_zero("reset_state");
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);

        // 1-cycle pulse on lane 0 stretched to MIN width
        a = cyc;
        push(CH_ANY, a + 1 + LAT, MINC);
        drive(0, 1, 1'b1);
        repeat (20) @(negedge CLK);

        // lane 1 held 10 cycles
        a = cyc;
        push(CH_ANY, a + 1 + LAT, 10);
        drive(1, 10, 1'b1);
        repeat (20) @(negedge CLK);

        // lane 2 re-request lands right at guard expiry: exactly GC low cycles between pauses
        a = cyc;
        push(CH_ANY, a + 1 + LAT, MINC);
        push(CH_ANY, a + 7 + LAT, MINC);
        drive(2, 1, 1'b1);
        repeat (5) @(negedge CLK);
        drive(2, 1, 1'b1);
        repeat (20) @(negedge CLK);

        // lane 3 re-request seen only while guard count is non-zero is dropped
        a = cyc;
        push(CH_ANY, a + 1 + LAT, MINC);
        drive(3, 1, 1'b1);
        repeat (4) @(negedge CLK);
        drive(3, 1, 1'b0);
        repeat (20) @(negedge CLK);

        // lane 0 re-request during ASSERT merges into the same 4-cycle pause
        a = cyc;
        push(CH_ANY, a + 1 + LAT, MINC);
        drive(0, 1, 1'b1);
        @(negedge CLK);
        drive(0, 1, 1'b0);
        repeat (20) @(negedge CLK);

        // all lanes staggered 0..3 cycles, each held 10
        a = cyc;
        for (int k = 0; k < NL; k++) push(k, a + k + 1 + LAT, 10);
        push(CH_ANY, a + 1 + LAT, 13);
        push(CH_ALL, a + 4 + LAT, 7);
        for (int t = 0; t < 14; t++) begin
            for (int k = 0; k < NL; k++) pause[k] = (t >= k) && (t < 10 + k);
            @(negedge CLK);
        end
        pause = '0;
        repeat (20) @(negedge CLK);

        // reset mid-ASSERT, input held high through release
        a = cyc;
        push(0, a + 1 + LAT, 1);
        push(CH_ANY, a + 1 + LAT, 1);
        pause[0] = 1'b1;
        repeat (LAT + 1) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_zero("async_reset_mid_pause");
        repeat (3) @(negedge CLK);
        check_zero("held_in_reset");
        RESET_N = 1'b1;
        c = cyc;
        push(0, c + 1 + LAT, 6);
        push(CH_ANY, c + 1 + LAT, 6);
        repeat (6) @(negedge CLK);
        pause[0] = 1'b0;
        repeat (25) @(negedge CLK);

        while (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_pause ch%0d: got no pause, required rise %0d width %0d",
                     exp_q[0].ch, exp_q[0].rise, exp_q[0].width);
            exp_q.delete(0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL timeout: got no completion, required finish within 200000 time units");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
